// File: rtl/mips_mc_controller.sv
// Multicycle MIPS controller: a Moore FSM that sequences one instruction
// over 3-5 states, plus the ALU decoder. A single memory port is shared
// between instruction fetch and data access. Each memory state waits on
// mem_ready, so the memory may take any number of cycles.
//
// Handshake: in FETCH, MEMRD and MEMWR the request (memread or memwrite)
// stays high on every cycle until the cycle in which mem_ready=1. That
// cycle completes the transfer, and the FSM leaves the state on the next
// clock edge. mem_ready is ignored in every other state.
module mips_mc_controller #(
   parameter int SUBWORD_EN = 1,
   parameter int BNE_EN     = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       memread,
   output logic       memwrite,
   output logic       iord,
   output logic       irwrite,
   output logic       pcen,
   output logic       regwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [2:0] alucontrol,
   output logic       ne,
   output logic       half,
   output logic       b,
   output logic       illegal,
   output logic [3:0] state
);

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MEMADR = 4'd2;
   localparam logic [3:0] S_MEMRD  = 4'd3;
   localparam logic [3:0] S_MEMWB  = 4'd4;
   localparam logic [3:0] S_MEMWR  = 4'd5;
   localparam logic [3:0] S_EXEC   = 4'd6;
   localparam logic [3:0] S_ALUWB  = 4'd7;
   localparam logic [3:0] S_BRANCH = 4'd8;
   localparam logic [3:0] S_ADDIEX = 4'd9;
   localparam logic [3:0] S_ADDIWB = 4'd10;
   localparam logic [3:0] S_JUMP   = 4'd11;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_LH    = 6'b100001;
   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   logic [3:0] state_q;
   logic [3:0] state_d;
   logic       is_load;
   logic       is_sw;
   logic       is_rtype;
   logic       is_branch;
   logic       is_bne;
   logic       is_addi;
   logic       is_j;
   logic       is_lh;
   logic       is_lb;
   logic       funct_ok;
   logic [2:0] funct_alu;

   // Instruction class decode from op/funct; subword loads and BNE are
   // recognised only when enabled, otherwise they fall through to illegal.
   always_comb begin
      is_lh     = (SUBWORD_EN != 0) && (op == OP_LH);
      is_lb     = (SUBWORD_EN != 0) && (op == OP_LB);
      is_load   = (op == OP_LW) || is_lh || is_lb;
      is_sw     = (op == OP_SW);
      is_rtype  = (op == OP_RTYPE);
      is_bne    = (BNE_EN != 0) && (op == OP_BNE);
      is_branch = (op == OP_BEQ) || is_bne;
      is_addi   = (op == OP_ADDI);
      is_j      = (op == OP_J);
      funct_ok  = 1'b1;
      funct_alu = ALU_ADD;
      case (funct)
         6'b100000: funct_alu = ALU_ADD;
         6'b100010: funct_alu = ALU_SUB;
         6'b100100: funct_alu = ALU_AND;
         6'b100101: funct_alu = ALU_OR;
         6'b101010: funct_alu = ALU_SLT;
         default:   funct_ok  = 1'b0;
      endcase
   end

   // Next-state logic; unused codes 12-15 recover to FETCH.
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            if (is_load || is_sw)         state_d = S_MEMADR;
            else if (is_rtype && funct_ok) state_d = S_EXEC;
            else if (is_branch)           state_d = S_BRANCH;
            else if (is_addi)             state_d = S_ADDIEX;
            else if (is_j)                state_d = S_JUMP;
            else                          state_d = S_FETCH;
         end
         S_MEMADR: state_d = is_sw ? S_MEMWR : S_MEMRD;
         S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWB:  state_d = S_FETCH;
         S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
         S_EXEC:   state_d = S_ALUWB;
         S_ALUWB:  state_d = S_FETCH;
         S_BRANCH: state_d = S_FETCH;
         S_ADDIEX: state_d = S_ADDIWB;
         S_ADDIWB: state_d = S_FETCH;
         S_JUMP:   state_d = S_FETCH;
         default:  state_d = S_FETCH;
      endcase
   end

   // State register with asynchronous return to FETCH.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   // Moore outputs per state; BRANCH pcen and FETCH irwrite/pcen also
   // depend on zero/mem_ready in the current cycle. Reset blanks everything.
   always_comb begin
      memread    = 1'b0;
      memwrite   = 1'b0;
      iord       = 1'b0;
      irwrite    = 1'b0;
      pcen       = 1'b0;
      regwrite   = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      alucontrol = ALU_ADD;
      ne         = 1'b0;
      half       = 1'b0;
      b          = 1'b0;
      illegal    = 1'b0;
      case (state_q)
         S_FETCH: begin
            memread = 1'b1;
            alusrcb = 2'b01;
            irwrite = mem_ready;
            pcen    = mem_ready;
         end
         S_DECODE: begin
            alusrcb = 2'b11;
            illegal = !(is_load || is_sw || (is_rtype && funct_ok) ||
                        is_branch || is_addi || is_j);
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_MEMRD: begin
            memread = 1'b1;
            iord    = 1'b1;
            half    = is_lh;
            b       = is_lb;
         end
         S_MEMWB: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
            half     = is_lh;
            b        = is_lb;
         end
         S_MEMWR: begin
            memwrite = 1'b1;
            iord     = 1'b1;
         end
         S_EXEC: begin
            alusrca    = 1'b1;
            alucontrol = funct_alu;
         end
         S_ALUWB: begin
            regwrite = 1'b1;
            regdst   = 1'b1;
         end
         S_BRANCH: begin
            alusrca    = 1'b1;
            pcsrc      = 2'b01;
            alucontrol = ALU_SUB;
            ne         = is_bne;
            pcen       = zero ^ is_bne;
         end
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_ADDIWB: regwrite = 1'b1;
         S_JUMP: begin
            pcsrc = 2'b10;
            pcen  = 1'b1;
         end
         default: ;
      endcase
      if (reset) begin
         memread    = 1'b0;
         memwrite   = 1'b0;
         iord       = 1'b0;
         irwrite    = 1'b0;
         pcen       = 1'b0;
         regwrite   = 1'b0;
         regdst     = 1'b0;
         memtoreg   = 1'b0;
         alusrca    = 1'b0;
         alusrcb    = 2'b00;
         pcsrc      = 2'b00;
         alucontrol = 3'b000;
         ne         = 1'b0;
         half       = 1'b0;
         b          = 1'b0;
         illegal    = 1'b0;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for mips_mc_controller: a per-cycle vector table for the
// instruction flows, plus hand-written sequences for the subword-disabled
// variant and for reset arriving during a stalled store.
module tb_mips_mc_controller;

   // Control word layout:
   // {memread,memwrite,iord,irwrite,pcen}_{regwrite,regdst,memtoreg,alusrca}
   // _{alusrcb}_{pcsrc}_{alucontrol}_{ne,half,b,illegal}
   localparam logic [19:0] C_RST   = 20'b00000_0000_00_00_000_0000;
   localparam logic [19:0] F_WAIT  = 20'b10000_0000_01_00_010_0000;
   localparam logic [19:0] F_RDY   = 20'b10011_0000_01_00_010_0000;
   localparam logic [19:0] DEC     = 20'b00000_0000_11_00_010_0000;
   localparam logic [19:0] DEC_IL  = 20'b00000_0000_11_00_010_0001;
   localparam logic [19:0] MADR    = 20'b00000_0001_10_00_010_0000;
   localparam logic [19:0] MRD     = 20'b10100_0000_00_00_010_0000;
   localparam logic [19:0] MRD_H   = 20'b10100_0000_00_00_010_0100;
   localparam logic [19:0] MRD_B   = 20'b10100_0000_00_00_010_0010;
   localparam logic [19:0] MWB     = 20'b00000_1010_00_00_010_0000;
   localparam logic [19:0] MWB_H   = 20'b00000_1010_00_00_010_0100;
   localparam logic [19:0] MWB_B   = 20'b00000_1010_00_00_010_0010;
   localparam logic [19:0] MWR     = 20'b01100_0000_00_00_010_0000;
   localparam logic [19:0] EX_ADD  = 20'b00000_0001_00_00_010_0000;
   localparam logic [19:0] EX_SUB  = 20'b00000_0001_00_00_110_0000;
   localparam logic [19:0] EX_AND  = 20'b00000_0001_00_00_000_0000;
   localparam logic [19:0] EX_OR   = 20'b00000_0001_00_00_001_0000;
   localparam logic [19:0] EX_SLT  = 20'b00000_0001_00_00_111_0000;
   localparam logic [19:0] ALUWB   = 20'b00000_1100_00_00_010_0000;
   localparam logic [19:0] AIEX    = 20'b00000_0001_10_00_010_0000;
   localparam logic [19:0] AIWB    = 20'b00000_1000_00_00_010_0000;
   localparam logic [19:0] BEQ_T   = 20'b00001_0001_00_01_110_0000;
   localparam logic [19:0] BEQ_NT  = 20'b00000_0001_00_01_110_0000;
   localparam logic [19:0] BNE_T   = 20'b00001_0001_00_01_110_1000;
   localparam logic [19:0] BNE_NT  = 20'b00000_0001_00_01_110_1000;
   localparam logic [19:0] JMP     = 20'b00001_0000_00_10_010_0000;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_LH   = 6'b100001;
   localparam logic [5:0] OP_LB   = 6'b100000;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_BAD  = 6'b111111;

   typedef struct {
      logic       rst;
      logic [5:0] op;
      logic [5:0] fn;
      logic       z;
      logic       rdy;
      logic [3:0] st;
      logic [19:0] ctl;
   } vec_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;

   logic       memread, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg, alusrca;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] alucontrol;
   logic       ne, half, b, illegal;
   logic [3:0] state;

   logic       n_memread, n_memwrite, n_iord, n_irwrite, n_pcen, n_regwrite, n_regdst;
   logic       n_memtoreg, n_alusrca;
   logic [1:0] n_alusrcb, n_pcsrc;
   logic [2:0] n_alucontrol;
   logic       n_ne, n_half, n_b, n_illegal;
   logic [3:0] n_state;

   logic [19:0] ctl, n_ctl;
   assign ctl = {memread, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg,
                 alusrca, alusrcb, pcsrc, alucontrol, ne, half, b, illegal};
   assign n_ctl = {n_memread, n_memwrite, n_iord, n_irwrite, n_pcen, n_regwrite, n_regdst,
                   n_memtoreg, n_alusrca, n_alusrcb, n_pcsrc, n_alucontrol, n_ne, n_half,
                   n_b, n_illegal};

   mips_mc_controller dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .memread(memread), .memwrite(memwrite), .iord(iord), .irwrite(irwrite), .pcen(pcen),
      .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
      .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .ne(ne), .half(half),
      .b(b), .illegal(illegal), .state(state)
   );

   mips_mc_controller #(.SUBWORD_EN(0), .BNE_EN(1)) dut_ns (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .memread(n_memread), .memwrite(n_memwrite), .iord(n_iord), .irwrite(n_irwrite),
      .pcen(n_pcen), .regwrite(n_regwrite), .regdst(n_regdst), .memtoreg(n_memtoreg),
      .alusrca(n_alusrca), .alusrcb(n_alusrcb), .pcsrc(n_pcsrc), .alucontrol(n_alucontrol),
      .ne(n_ne), .half(n_half), .b(n_b), .illegal(n_illegal), .state(n_state)
   );

   // ---------------- driver / checker tasks ----------------
   int n_vec = 0;
   int n_err = 0;
   vec_t vecs[$];

   task automatic add(input logic rst, input logic [5:0] o, input logic [5:0] f,
                      input logic z, input logic r, input logic [3:0] st,
                      input logic [19:0] c);
      vec_t v;
      v.rst = rst; v.op = o; v.fn = f; v.z = z; v.rdy = r; v.st = st; v.ctl = c;
      vecs.push_back(v);
   endtask

   // Drive inputs just after the falling edge, settle, then sample.
   task automatic step(input logic rst, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic r);
      @(negedge clk);
      reset = rst; op = o; funct = f; zero = z; mem_ready = r;
      #1;
   endtask

   task automatic check(input string name, input logic [3:0] act_st, input logic [19:0] act_ctl,
                        input logic [3:0] exp_st, input logic [19:0] exp_ctl);
      n_vec++;
      if (act_st !== exp_st || act_ctl !== exp_ctl) begin
         n_err++;
         $display("FAIL %s: got state=%0d ctl=%b, expected state=%0d ctl=%b",
                  name, act_st, act_ctl, exp_st, exp_ctl);
      end
   endtask

   // ---------------- test ----------------
   logic [5:0]  fn_tab [5];
   logic [19:0] ex_tab [5];

   initial begin
      reset = 1'b1; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;

      fn_tab[0] = 6'b100000; ex_tab[0] = EX_ADD;
      fn_tab[1] = 6'b100010; ex_tab[1] = EX_SUB;
      fn_tab[2] = 6'b100100; ex_tab[2] = EX_AND;
      fn_tab[3] = 6'b100101; ex_tab[3] = EX_OR;
      fn_tab[4] = 6'b101010; ex_tab[4] = EX_SLT;

      add(1, OP_R, 6'b100000, 0, 1, 0, C_RST);
      // R-type add with mem_ready always high: 0,1,6,7
      add(0, OP_R, 6'b100000, 0, 1, 0, F_RDY);
      add(0, OP_R, 6'b100000, 0, 1, 1, DEC);
      add(0, OP_R, 6'b100000, 0, 1, 6, EX_ADD);
      add(0, OP_R, 6'b100000, 0, 1, 7, ALUWB);
      // remaining functs; mem_ready low outside FETCH must not stall
      for (int i = 1; i < 5; i++) begin
         add(0, OP_R, fn_tab[i], 0, 1, 0, F_RDY);
         add(0, OP_R, fn_tab[i], 0, 0, 1, DEC);
         add(0, OP_R, fn_tab[i], 0, 0, 6, ex_tab[i]);
         add(0, OP_R, fn_tab[i], 0, 0, 7, ALUWB);
      end
      // ADDI
      add(0, OP_ADDI, 6'h00, 0, 1, 0, F_RDY);
      add(0, OP_ADDI, 6'h00, 0, 1, 1, DEC);
      add(0, OP_ADDI, 6'h00, 0, 1, 9, AIEX);
      add(0, OP_ADDI, 6'h00, 0, 1, 10, AIWB);
      // J
      add(0, OP_J, 6'h00, 0, 1, 0, F_RDY);
      add(0, OP_J, 6'h00, 0, 1, 1, DEC);
      add(0, OP_J, 6'h00, 0, 1, 11, JMP);
      // BEQ taken / not taken, BNE taken / not taken
      add(0, OP_BEQ, 6'h00, 1, 1, 0, F_RDY);
      add(0, OP_BEQ, 6'h00, 1, 1, 1, DEC);
      add(0, OP_BEQ, 6'h00, 1, 1, 8, BEQ_T);
      add(0, OP_BEQ, 6'h00, 0, 1, 0, F_RDY);
      add(0, OP_BEQ, 6'h00, 0, 1, 1, DEC);
      add(0, OP_BEQ, 6'h00, 0, 1, 8, BEQ_NT);
      add(0, OP_BNE, 6'h00, 0, 1, 0, F_RDY);
      add(0, OP_BNE, 6'h00, 0, 1, 1, DEC);
      add(0, OP_BNE, 6'h00, 0, 1, 8, BNE_T);
      add(0, OP_BNE, 6'h00, 1, 1, 0, F_RDY);
      add(0, OP_BNE, 6'h00, 1, 1, 1, DEC);
      add(0, OP_BNE, 6'h00, 1, 1, 8, BNE_NT);
      // LW with two wait cycles in FETCH and in MEMRD: 9 cycles total
      add(0, OP_LW, 6'h00, 0, 0, 0, F_WAIT);
      add(0, OP_LW, 6'h00, 0, 0, 0, F_WAIT);
      add(0, OP_LW, 6'h00, 0, 1, 0, F_RDY);
      add(0, OP_LW, 6'h00, 0, 1, 1, DEC);
      add(0, OP_LW, 6'h00, 0, 1, 2, MADR);
      add(0, OP_LW, 6'h00, 0, 0, 3, MRD);
      add(0, OP_LW, 6'h00, 0, 0, 3, MRD);
      add(0, OP_LW, 6'h00, 0, 1, 3, MRD);
      add(0, OP_LW, 6'h00, 0, 1, 4, MWB);
      // LH and LB, zero-wait
      add(0, OP_LH, 6'h00, 0, 1, 0, F_RDY);
      add(0, OP_LH, 6'h00, 0, 1, 1, DEC);
      add(0, OP_LH, 6'h00, 0, 1, 2, MADR);
      add(0, OP_LH, 6'h00, 0, 1, 3, MRD_H);
      add(0, OP_LH, 6'h00, 0, 1, 4, MWB_H);
      add(0, OP_LB, 6'h00, 0, 1, 0, F_RDY);
      add(0, OP_LB, 6'h00, 0, 1, 1, DEC);
      add(0, OP_LB, 6'h00, 0, 1, 2, MADR);
      add(0, OP_LB, 6'h00, 0, 1, 3, MRD_B);
      add(0, OP_LB, 6'h00, 0, 1, 4, MWB_B);
      // SW with one wait cycle
      add(0, OP_SW, 6'h00, 0, 1, 0, F_RDY);
      add(0, OP_SW, 6'h00, 0, 1, 1, DEC);
      add(0, OP_SW, 6'h00, 0, 1, 2, MADR);
      add(0, OP_SW, 6'h00, 0, 0, 5, MWR);
      add(0, OP_SW, 6'h00, 0, 1, 5, MWR);
      // illegal op, then illegal R-type funct; each returns straight to FETCH
      add(0, OP_BAD, 6'h00, 0, 1, 0, F_RDY);
      add(0, OP_BAD, 6'h00, 0, 1, 1, DEC_IL);
      add(0, OP_R, 6'b000001, 0, 1, 0, F_RDY);
      add(0, OP_R, 6'b000001, 0, 1, 1, DEC_IL);
      add(0, OP_R, 6'b000001, 0, 0, 0, F_WAIT);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].rst, vecs[i].op, vecs[i].fn, vecs[i].z, vecs[i].rdy);
         check($sformatf("vec%0d", i), state, ctl, vecs[i].st, vecs[i].ctl);
      end

      // LB on both builds: default decodes a byte load, subword-disabled
      // flags it illegal and never writes a register.
      step(1, OP_LB, 6'h00, 0, 1);
      check("lb_rst", state, ctl, 0, C_RST);
      check("lb_ns_rst", n_state, n_ctl, 0, C_RST);
      step(0, OP_LB, 6'h00, 0, 1);
      check("lb_fetch", state, ctl, 0, F_RDY);
      check("lb_ns_fetch", n_state, n_ctl, 0, F_RDY);
      step(0, OP_LB, 6'h00, 0, 0);
      check("lb_dec", state, ctl, 1, DEC);
      check("lb_ns_dec", n_state, n_ctl, 1, DEC_IL);
      step(0, OP_LB, 6'h00, 0, 0);
      check("lb_madr", state, ctl, 2, MADR);
      check("lb_ns_back", n_state, n_ctl, 0, F_WAIT);
      step(0, OP_LB, 6'h00, 0, 1);
      check("lb_memrd", state, ctl, 3, MRD_B);
      check("lb_ns_fetch2", n_state, n_ctl, 0, F_RDY);
      step(0, OP_LB, 6'h00, 0, 1);
      check("lb_memwb", state, ctl, 4, MWB_B);
      check("lb_ns_dec2", n_state, n_ctl, 1, DEC_IL);

      // SW stalled, reset during the second waiting cycle
      step(1, OP_SW, 6'h00, 0, 1);
      check("sw_rst", state, ctl, 0, C_RST);
      step(0, OP_SW, 6'h00, 0, 1);
      check("sw_fetch", state, ctl, 0, F_RDY);
      step(0, OP_SW, 6'h00, 0, 1);
      check("sw_dec", state, ctl, 1, DEC);
      step(0, OP_SW, 6'h00, 0, 0);
      check("sw_madr", state, ctl, 2, MADR);
      step(0, OP_SW, 6'h00, 0, 0);
      check("sw_wait1", state, ctl, 5, MWR);
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      check("sw_wait2", state, ctl, 5, MWR);
      #1;
      reset = 1'b1;
      #1;
      check("sw_mid_rst", state, ctl, 0, C_RST);
      step(0, OP_SW, 6'h00, 0, 0);
      check("sw_restart", state, ctl, 0, F_WAIT);
      step(0, OP_SW, 6'h00, 0, 0);
      check("sw_restart2", state, ctl, 0, F_WAIT);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
